// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between the I-cache refill
// path (read-only) and the D-cache path (read/write). Data requests win
// arbitration, but once MAX_D_STREAK data grants in a row have gone by while a
// fetch was waiting, the fetch is forced through. Every transaction runs
// grant -> strobe held until mem_ready -> one-cycle ack to the owner.
//
// Handshakes:
//   requester side: req is raised with a stable payload and held until the
//   one-cycle ack; rdata is valid in the ack cycle and holds until the next
//   read by the same owner.
//   memory side: exactly one of mem_read/mem_write is held with a stable
//   mem_addr/mem_wdata until a one-cycle mem_ready; read data is taken in
//   the mem_ready cycle.
// fsm_state exposes the controller state (0 = IDLE, 1 = I_BUSY, 2 = D_BUSY,
// 3 = ACK) and streak_cnt the consecutive-data-grant counter.
module mem_port_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        fsm_state,
    output logic [3:0]        streak_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_I_BUSY = 2'd1;
    localparam logic [1:0] S_D_BUSY = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [3:0] streak;
    logic       force_i;
    logic       grant_d;
    logic       grant_i;
    logic       mem_done;

    // Arbitration is only evaluated in IDLE; a waiting fetch overrides data
    // once the data streak has reached its limit.
    assign force_i  = i_req && (streak == STREAK_MAX);
    assign grant_d  = (state == S_IDLE) && d_req && !force_i;
    assign grant_i  = (state == S_IDLE) && !grant_d && i_req;
    assign mem_done = ((state == S_I_BUSY) || (state == S_D_BUSY)) && mem_ready;

    assign fsm_state  = state;
    assign streak_cnt = streak;

    // Next-state selection: IDLE -> BUSY on grant, BUSY -> ACK on mem_ready,
    // ACK always returns to IDLE without sampling requests.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant_d) begin
                    state_next = S_D_BUSY;
                end else if (grant_i) begin
                    state_next = S_I_BUSY;
                end
            end
            S_I_BUSY, S_D_BUSY: begin
                if (mem_ready) begin
                    state_next = S_ACK;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Consecutive data grants while a fetch waits; any fetch grant or an
    // uncontended data grant starts the count over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= 4'd0;
        end else if (grant_d) begin
            if (!i_req) begin
                streak <= 4'd0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 4'd1;
            end
        end else if (grant_i) begin
            streak <= 4'd0;
        end
    end

    // Memory-side registers: the winning request is latched at grant and the
    // strobe is held until mem_ready, so requester changes mid-transaction
    // cannot disturb the port. A fetch never drives write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_d) begin
            mem_read  <= !d_wen;
            mem_write <= d_wen;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end else if (grant_i) begin
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
        end else if (mem_done) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    // One-cycle ack to whichever requester owns the completing transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
        end else begin
            i_ack <= mem_done && (state == S_I_BUSY);
            d_ack <= mem_done && (state == S_D_BUSY);
        end
    end

    // Read data capture; a data write leaves d_rdata untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (mem_done) begin
            if (state == S_I_BUSY) begin
                i_rdata <= mem_rdata;
            end else if (mem_read) begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a table of single transactions, hand-written
// multi-cycle sequences (contention, streak limit, reset mid-transaction,
// stray mem_ready) and a randomized phase checked against a transaction-level
// reference model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int AW    = 28;
    localparam int DW    = 128;
    localparam int MAX_D = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req, d_req, d_wen, mem_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          i_ack, d_ack, mem_read, mem_write;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    fsm_state;
    logic [3:0]    streak_cnt;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAX_D)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .fsm_state(fsm_state), .streak_cnt(streak_cnt)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_i_rdata;
    logic [DW-1:0] exp_d_rdata;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit            is_d;
        bit            wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            wait_n;
        logic [DW-1:0] rdata;
        bit            exp_read;
        bit            exp_write;
        int            exp_lat;
    } vec_t;

    vec_t vecs[6];

    // Called just after a negedge with the DUT idle; returns the same way.
    task automatic run_vec(input vec_t v, input int idx);
        int ack_cyc;
        int strobe_n;
        ack_cyc  = -1;
        strobe_n = 0;
        if (v.is_d) begin
            d_req = 1'b1; d_wen = v.wen; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        for (int cyc = 1; cyc <= 12 && ack_cyc < 0; cyc++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (i_ack || d_ack) begin
                ack_cyc = cyc;
                chk($sformatf("vec%0d_owner_ack", idx), v.is_d ? d_ack : i_ack, 1);
                chk($sformatf("vec%0d_other_ack", idx), v.is_d ? i_ack : d_ack, 0);
                if (!v.is_d) exp_i_rdata = v.rdata;
                else if (!v.wen) exp_d_rdata = v.rdata;
                chk($sformatf("vec%0d_i_rdata", idx), i_rdata, exp_i_rdata);
                chk($sformatf("vec%0d_d_rdata", idx), d_rdata, exp_d_rdata);
                chk($sformatf("vec%0d_strobes_low", idx), {mem_read, mem_write}, 0);
            end else if (mem_read || mem_write) begin
                chk($sformatf("vec%0d_mem_read", idx), mem_read, v.exp_read);
                chk($sformatf("vec%0d_mem_write", idx), mem_write, v.exp_write);
                chk($sformatf("vec%0d_mem_addr", idx), mem_addr, v.addr);
                if (v.exp_write) chk($sformatf("vec%0d_mem_wdata", idx), mem_wdata, v.wdata);
                if (strobe_n == v.wait_n) begin
                    mem_ready = 1'b1;
                    mem_rdata = v.rdata;
                end
                strobe_n++;
            end
        end
        mem_ready = 1'b0;
        chk($sformatf("vec%0d_ack_latency", idx), ack_cyc, v.exp_lat);
        chk($sformatf("vec%0d_strobe_cycles", idx), strobe_n, v.wait_n + 1);
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        chk($sformatf("vec%0d_ack_pulse", idx), {i_ack, d_ack}, 0);
        chk($sformatf("vec%0d_back_idle", idx), fsm_state, ST_IDLE);
    endtask

    // Waits (bounded) for a strobe, answers it after wait_n extra cycles and
    // checks the ack. who: 1 = data owner, 0 = fetch owner, -1 = unknown.
    task automatic serve_one(input int wait_n, output int who);
        int guard;
        logic [DW-1:0] rd;
        guard = 0;
        who   = -1;
        while (!(mem_read || mem_write) && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("serve_strobe_seen", mem_read | mem_write, 1);
        if (!(mem_read || mem_write)) return;
        if (mem_addr == d_addr) who = 1;
        else if (mem_addr == i_addr) who = 0;
        repeat (wait_n) @(negedge clk);
        rd = rand_line();
        mem_ready = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("serve_owner_ack", (who == 1) ? d_ack : i_ack, 1);
        chk("serve_other_ack", (who == 1) ? i_ack : d_ack, 0);
        if (who == 1) begin
            exp_d_rdata = rd;
            chk("serve_d_rdata", d_rdata, exp_d_rdata);
        end else begin
            exp_i_rdata = rd;
            chk("serve_i_rdata", i_rdata, exp_i_rdata);
        end
    endtask

    // ---------------- random-phase reference model state ----------------
    int            who;
    bit            bsy, ack_due, own_d, exp_wr, pd, pi, done_i, done_d;
    int            streak_m, wait_left, stall, n_tx;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd, rd_data;

    initial begin
        vecs[0] = '{is_d: 1, wen: 0, addr: 28'h10, wdata: '0, wait_n: 0,
                    rdata: {4{32'hDEAD_0010}}, exp_read: 1, exp_write: 0, exp_lat: 2};
        vecs[1] = '{is_d: 1, wen: 1, addr: 28'h20, wdata: {16{8'hA5}}, wait_n: 3,
                    rdata: {4{32'h0BAD_0BAD}}, exp_read: 0, exp_write: 1, exp_lat: 5};
        vecs[2] = '{is_d: 0, wen: 0, addr: 28'h30, wdata: '0, wait_n: 1,
                    rdata: {4{32'h1234_5678}}, exp_read: 1, exp_write: 0, exp_lat: 3};
        vecs[3] = '{is_d: 1, wen: 0, addr: 28'h44, wdata: '0, wait_n: 2,
                    rdata: {4{32'hCAFE_F00D}}, exp_read: 1, exp_write: 0, exp_lat: 4};
        vecs[4] = '{is_d: 0, wen: 0, addr: 28'hFFF_FFFF, wdata: '0, wait_n: 0,
                    rdata: {4{32'h8765_4321}}, exp_read: 1, exp_write: 0, exp_lat: 2};
        vecs[5] = '{is_d: 1, wen: 1, addr: 28'hABC_DEF0, wdata: {2{64'h0123_4567_89AB_CDEF}},
                    wait_n: 0, rdata: {4{32'h5555_AAAA}}, exp_read: 0, exp_write: 1, exp_lat: 2};

        i_req = 0; d_req = 0; d_wen = 0; mem_ready = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        exp_i_rdata = '0; exp_d_rdata = '0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_strobes", {mem_read, mem_write}, 0);
        chk("rst_acks", {i_ack, d_ack}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_state", fsm_state, ST_IDLE);
        chk("rst_streak", streak_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- table-driven single transactions ----
        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // ---- simultaneous requests: data first, fetch after one idle gap ----
        i_req = 1; i_addr = 28'h100;
        d_req = 1; d_wen = 0; d_addr = 28'h200;
        serve_one(0, who);
        chk("sim_first_is_d", who, 1);
        d_req = 0;
        @(negedge clk);
        chk("sim_gap_idle", {mem_read, mem_write}, 0);
        @(negedge clk);
        chk("sim_i_grant", {mem_read, mem_write}, 2'b10);
        chk("sim_i_addr", mem_addr, 28'h100);
        serve_one(1, who);
        chk("sim_second_is_i", who, 0);
        i_req = 0;
        @(negedge clk);

        // ---- streak limit: fetch held, data re-raised after every ack ----
        i_req = 1; i_addr = 28'h300;
        d_req = 1; d_wen = 0; d_addr = 28'h400;
        for (int k = 0; k < MAX_D; k++) begin
            serve_one(k % 3, who);
            chk($sformatf("streak_d%0d_owner", k), who, 1);
        end
        chk("streak_at_limit", streak_cnt, MAX_D);
        serve_one(0, who);
        chk("streak_forced_i", who, 0);
        chk("streak_cleared", streak_cnt, 0);
        i_req = 0;
        serve_one(0, who);
        chk("streak_d_after_i", who, 1);
        chk("streak_still_zero", streak_cnt, 0);
        d_req = 0;
        @(negedge clk);

        // ---- stray mem_ready while idle ----
        mem_ready = 1; mem_rdata = rand_line();
        @(negedge clk);
        mem_ready = 0;
        chk("stray_strobes", {mem_read, mem_write}, 0);
        chk("stray_acks", {i_ack, d_ack}, 0);
        chk("stray_state", fsm_state, ST_IDLE);
        chk("stray_i_rdata", i_rdata, exp_i_rdata);
        chk("stray_d_rdata", d_rdata, exp_d_rdata);
        @(negedge clk);
        chk("stray_acks_later", {i_ack, d_ack}, 0);

        // ---- reset asserted during a data write ----
        d_req = 1; d_wen = 1; d_addr = 28'h500; d_wdata = rand_line();
        @(negedge clk);
        chk("rmid_write_strobe", mem_write, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_strobes", {mem_read, mem_write}, 0);
        chk("rmid_addr", mem_addr, 0);
        chk("rmid_wdata", mem_wdata, 0);
        chk("rmid_acks", {i_ack, d_ack}, 0);
        chk("rmid_i_rdata", i_rdata, 0);
        chk("rmid_d_rdata", d_rdata, 0);
        chk("rmid_state", fsm_state, ST_IDLE);
        d_req = 0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rmid_no_ack", {i_ack, d_ack}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[0], 10);

        // ---- randomized traffic against the reference model ----
        bsy = 0; ack_due = 0; own_d = 0; exp_wr = 0; streak_m = 0;
        wait_left = 0; stall = 0; n_tx = 0; exp_addr = '0; exp_wd = '0; rd_data = '0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            done_i = 0;
            done_d = 0;
            mem_ready = 0;
            chk("rnd_strobe_excl", mem_read & mem_write, 0);
            if (ack_due) begin
                ack_due = 0; bsy = 0; stall = 0; n_tx++;
                chk("rnd_i_ack", i_ack, !own_d);
                chk("rnd_d_ack", d_ack, own_d);
                if (!own_d) exp_i_rdata = rd_data;
                else if (!exp_wr) exp_d_rdata = rd_data;
                chk("rnd_i_rdata", i_rdata, exp_i_rdata);
                chk("rnd_d_rdata", d_rdata, exp_d_rdata);
                if (own_d) done_d = 1; else done_i = 1;
            end else begin
                chk("rnd_no_ack", {i_ack, d_ack}, 0);
            end
            if ((mem_read || mem_write) && !bsy) begin
                // A new transaction appeared: decide from the requests the
                // arbiter saw who should have won.
                pd = d_req && !(i_req && streak_m == MAX_D);
                pi = !pd && i_req;
                chk("rnd_grant_had_req", pd | pi, 1);
                own_d    = pd;
                exp_addr = pd ? d_addr : i_addr;
                exp_wr   = pd && d_wen;
                exp_wd   = d_wdata;
                if (pd) streak_m = i_req ? ((streak_m < MAX_D) ? streak_m + 1 : MAX_D) : 0;
                else streak_m = 0;
                bsy = 1; stall = 0;
                wait_left = $urandom_range(0, 3);
            end
            if (bsy && (mem_read || mem_write)) begin
                chk("rnd_mem_addr", mem_addr, exp_addr);
                chk("rnd_mem_write", mem_write, exp_wr);
                chk("rnd_mem_read", mem_read, !exp_wr);
                if (exp_wr) chk("rnd_mem_wdata", mem_wdata, exp_wd);
                if (wait_left == 0) begin
                    rd_data = rand_line();
                    mem_ready = 1; mem_rdata = rd_data; ack_due = 1;
                end else begin
                    wait_left--;
                end
            end else if (!bsy && $urandom_range(0, 7) == 0) begin
                mem_ready = 1; mem_rdata = rand_line();
            end
            if (i_req || d_req || bsy) stall++;
            if (stall > 16) begin
                chk("rnd_progress_stall", stall, 16);
                break;
            end
            if (done_i) i_req = 0;
            if (done_d) d_req = 0;
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = AW'($urandom());
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_wen = 1'($urandom_range(0, 1));
                d_addr = AW'($urandom()); d_wdata = rand_line();
            end
        end
        i_req = 0; d_req = 0; mem_ready = 0;
        chk("rnd_some_traffic", n_tx > 100, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
